// File: rtl/counter_m_pkg.sv
// Shared constants and helpers for the counter_m block.
// Imported by the counter, its toggle cell, and any bench or user.
package counter_m_pkg;

    // Width used when the parent does not override N.
    localparam int COUNTER_M_DEFAULT_N = 4;

    // Largest count an n-bit counter reaches before wrapping (2^n - 1).
    // Saturates at 32 bits because the return type is 32 bits wide.
    function automatic int unsigned counter_m_terminal(input int n);
        if (n >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/counter_m_bit.sv
// Single toggle cell of the synchronous-carry counter.
// Flips when t is high, clears on a synchronous reset.
module counter_m_bit
    import counter_m_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic r_q;

    // Toggle flop: reset wins, otherwise flip on t.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/counter_m.sv
// N-bit synchronous up-counter, wraps modulo 2^N.
// Built from N toggle cells driven by an AND carry chain on one clock.
module counter_m
    import counter_m_pkg::*;
#(
    parameter int N = COUNTER_M_DEFAULT_N
) (
    output logic [N-1:0] out,
    input  logic         clk,
    input  logic         reset,
    input  logic         enable
);

    if (N < 1) begin : g_bad_n
        $error("counter_m: N must be at least 1");
    end

    logic [N-1:0] w_q;
    logic [N-1:0] w_t;
    logic [N-1:0] w_inc;

    // Bit i toggles when enabled and every lower bit is already 1.
    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign w_t[i] = enable;
        end else begin : g_chain
            assign w_t[i] = w_t[i-1] & w_q[i-1];
        end

        counter_m_bit u_bit (
            .clk   (clk),
            .reset (reset),
            .t     (w_t[i]),
            .q     (w_q[i])
        );
    end

    assign out = w_q;

    // N-bit increment so the carry out of the top bit is dropped.
    assign w_inc = w_q + 1'b1;

    a_reset_clears : assert property (
        @(posedge clk) reset |=> (out == '0)
    ) else $error("counter_m: out not zero after reset");

    a_enable_steps : assert property (
        @(posedge clk) (!reset && enable) |=> (out == $past(w_inc))
    ) else $error("counter_m: out did not step by one");

    a_disable_holds : assert property (
        @(posedge clk) (!reset && !enable) |=> $stable(out)
    ) else $error("counter_m: out changed while disabled");

endmodule

// File: tb/tb_counter_m.sv
// Directed and random checks of counter_m at N=5, N=4 (default), N=1.
// Expected values come from hand tables and a small reference model.
module tb_counter_m;
    import counter_m_pkg::*;

    logic       clk = 1'b0;
    logic       rst5, en5, rst4, en4, rst1, en1;
    logic [4:0] out5;
    logic [3:0] out4;
    logic [0:0] out1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic rst;
        logic en;
        int   exp;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    counter_m #(.N(5)) u_n5 (
        .out    (out5),
        .clk    (clk),
        .reset  (rst5),
        .enable (en5)
    );

    counter_m u_n4 (
        .out    (out4),
        .clk    (clk),
        .reset  (rst4),
        .enable (en4)
    );

    counter_m #(.N(1)) u_n1 (
        .out    (out1),
        .clk    (clk),
        .reset  (rst1),
        .enable (en1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input int x);
        vec_t v;
        v.rst = r;
        v.en  = e;
        v.exp = x;
        vq.push_back(v);
    endtask

    initial begin
        int m;
        int tc5;
        rst5 = 1'b0; en5 = 1'b0;
        rst4 = 1'b0; en4 = 1'b0;
        rst1 = 1'b0; en1 = 1'b0;
        tc5 = int'(counter_m_terminal(5));

        // Hold/resume and mid-count reset sequence at N=5.
        add(1'b1, 1'b0, 0);
        for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, i);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 7);
        add(1'b0, 1'b1, 8);
        for (int i = 9; i <= 13; i++) add(1'b0, 1'b1, i);
        add(1'b1, 1'b1, 0);
        add(1'b1, 1'b1, 0);
        add(1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1);

        @(negedge clk);

        // Test 1: reset then 40 enabled cycles, one wrap at 31.
        rst5 = 1'b1; en5 = 1'b1;
        tick();
        chk("n5_reset", int'(out5), 0);
        rst5 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("n5_count", int'(out5), (i + 1) % 32);
        end

        // Tests 2 and 3 from the table.
        foreach (vq[k]) begin
            rst5 = vq[k].rst;
            en5  = vq[k].en;
            tick();
            chk($sformatf("n5_vec%0d", k), int'(out5), vq[k].exp);
        end

        // Test 4: default width, period 16.
        rst4 = 1'b1; en4 = 1'b0;
        tick();
        chk("n4_reset", int'(out4), 0);
        rst4 = 1'b0; en4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("n4_count", int'(out4), (i + 1) % 16);
        end

        // Test 5: N=1 toggles when enabled, holds otherwise.
        rst1 = 1'b1; en1 = 1'b1;
        tick();
        chk("n1_reset", int'(out1), 0);
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n1_toggle", int'(out1), (i + 1) % 2);
        end
        en1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("n1_hold0", int'(out1), 0);
        end
        en1 = 1'b1;
        tick();
        chk("n1_toggle1", int'(out1), 1);
        en1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("n1_hold1", int'(out1), 1);
        end

        // Test 6: random reset/enable against a reference model.
        rst5 = 1'b1; en5 = 1'b0;
        tick();
        m = 0;
        chk("n5_rnd_reset", int'(out5), m);
        for (int i = 0; i < 1000; i++) begin
            rst5 = ($urandom_range(0, 19) == 0);
            en5  = ($urandom_range(0, 3) != 0);
            tick();
            if (rst5) m = 0;
            else if (en5) m = (m == tc5) ? 0 : m + 1;
            chk("n5_random", int'(out5), m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
